// File: rtl/updown_counter_pkg.sv
// updown_counter_pkg: shared constants and parameter-legality helper for the
// up/down counter slice.
// Optional feature macro: UPDOWN_COUNTER_SAT_EN (saturating mode, see
// updown_counter_next.sv).
package updown_counter_pkg;

   // Direction encoding on the ctrl input.
   localparam logic DIR_UP = 1'b1;
   localparam logic DIR_DN = 1'b0;

   // True when WIDTH is 2..32 and MAX_VAL is 1..2**WIDTH-1.
   function automatic bit params_ok(input int width, input longint unsigned max_val);
      longint unsigned lim;
      if (width < 2 || width > 32) return 1'b0;
      lim = (64'd1 << width) - 64'd1;
      return (max_val >= 64'd1) && (max_val <= lim);
   endfunction

endpackage

// File: rtl/updown_counter_if.sv
// updown_counter_if: control and status bundle of the up/down counter.
// Optional feature macro: UPDOWN_COUNTER_SAT_EN (no effect on this file).
// Control inputs are plain level/strobe signals sampled on every rising clk
// edge; there is no valid/ready flow control, so the counter always accepts
// the control word present at the edge.
interface updown_counter_if #(
   parameter int WIDTH = 8
);
   logic             en;
   logic             ctrl;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic [WIDTH-1:0] cnt;
   logic             carry;
   logic             borrow;
   logic             at_max;
   logic             at_min;

   modport master (
      output en, ctrl, load, load_val,
      input  cnt, carry, borrow, at_max, at_min
   );

   modport slave (
      input  en, ctrl, load, load_val,
      output cnt, carry, borrow, at_max, at_min
   );
endinterface

// File: rtl/updown_counter_next.sv
// updown_counter_next: combinational next-count and boundary-event logic.
// Optional feature macro: UPDOWN_COUNTER_SAT_EN -- when defined, the count
// holds at the boundary instead of wrapping and the event flags mean
// "blocked count".
module updown_counter_next
   import updown_counter_pkg::*;
#(
   parameter int               WIDTH   = 8,
   parameter logic [WIDTH-1:0] MAX_VAL = '1
) (
   input  logic [WIDTH-1:0] cnt,
   input  logic             ctrl,
   input  logic             en,
   output logic [WIDTH-1:0] next_cnt,
   output logic             evt_carry,
   output logic             evt_borrow
);

   // Next count for one enabled step; a boundary step raises exactly one flag.
   always_comb begin
      next_cnt   = cnt;
      evt_carry  = 1'b0;
      evt_borrow = 1'b0;
      if (en) begin
         if (ctrl == DIR_UP) begin
            if (cnt == MAX_VAL) begin
`ifdef UPDOWN_COUNTER_SAT_EN
               next_cnt = MAX_VAL;
`else
               next_cnt = '0;
`endif
               evt_carry = 1'b1;
            end else begin
               next_cnt = cnt + WIDTH'(1);
            end
         end else begin
            if (cnt == '0) begin
`ifdef UPDOWN_COUNTER_SAT_EN
               next_cnt = '0;
`else
               next_cnt = MAX_VAL;
`endif
               evt_borrow = 1'b1;
            end else begin
               next_cnt = cnt - WIDTH'(1);
            end
         end
      end
   end

endmodule

// File: rtl/updown_counter_n.sv
// updown_counter_n: WIDTH-bit up/down counter with terminal count MAX_VAL,
// clamped parallel load, one-cycle carry/borrow pulses and at_max/at_min flags.
// Optional feature macro: UPDOWN_COUNTER_SAT_EN (saturating instead of wrapping).
module updown_counter_n
   import updown_counter_pkg::*;
#(
   parameter int              WIDTH   = 8,
   parameter longint unsigned MAX_VAL = (64'd1 << WIDTH) - 64'd1
) (
   input logic              clk,
   input logic              rst_n,
   updown_counter_if.slave  bus
);

   localparam logic [WIDTH-1:0] MAX_C = MAX_VAL[WIDTH-1:0];

   if (!params_ok(WIDTH, MAX_VAL)) begin : g_bad_params
      $error("updown_counter_n: illegal WIDTH/MAX_VAL combination");
   end

   logic [WIDTH-1:0] cnt_q;
   logic             carry_q;
   logic             borrow_q;
   logic [WIDTH-1:0] next_cnt;
   logic             evt_carry;
   logic             evt_borrow;
   logic [WIDTH-1:0] load_clamped;

   updown_counter_next #(
      .WIDTH   (WIDTH),
      .MAX_VAL (MAX_C)
   ) u_next (
      .cnt        (cnt_q),
      .ctrl       (bus.ctrl),
      .en         (bus.en),
      .next_cnt   (next_cnt),
      .evt_carry  (evt_carry),
      .evt_borrow (evt_borrow)
   );

   // Loaded values above the terminal count are pulled down to MAX_VAL.
   always_comb begin
      load_clamped = bus.load_val;
      if (bus.load_val > MAX_C) load_clamped = MAX_C;
   end

   // Count register: reset, then load, then enabled step, else hold.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q    <= '0;
         carry_q  <= 1'b0;
         borrow_q <= 1'b0;
      end else if (bus.load) begin
         cnt_q    <= load_clamped;
         carry_q  <= 1'b0;
         borrow_q <= 1'b0;
      end else if (bus.en) begin
         cnt_q    <= next_cnt;
         carry_q  <= evt_carry;
         borrow_q <= evt_borrow;
      end else begin
         carry_q  <= 1'b0;
         borrow_q <= 1'b0;
      end
   end

   assign bus.cnt    = cnt_q;
   assign bus.carry  = carry_q;
   assign bus.borrow = borrow_q;
   assign bus.at_max = (cnt_q == MAX_C);
   assign bus.at_min = (cnt_q == '0);

endmodule

// File: tb/tb_updown_counter_n.sv
// tb_updown_counter_n: two counter instances (4-bit/15 and 8-bit/9), a vector
// table, hand-written corner sequences and a randomized run against a
// behavioural model. Honours UPDOWN_COUNTER_SAT_EN.
module tb_updown_counter_n;

`ifdef UPDOWN_COUNTER_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   localparam int MAX_A = 15;
   localparam int MAX_B = 9;

   // Clock and reset
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   updown_counter_if #(.WIDTH(4)) bus_a ();
   updown_counter_if #(.WIDTH(8)) bus_b ();

   updown_counter_n #(.WIDTH(4), .MAX_VAL(64'd15)) dut_a (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_a.slave)
   );

   updown_counter_n #(.WIDTH(8), .MAX_VAL(64'd9)) dut_b (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_b.slave)
   );

   int total = 0;
   int bad   = 0;

   typedef struct {
      bit rst_n;
      bit load;
      bit en;
      bit ctrl;
      int load_val;
      int exp_cnt;
      bit exp_carry;
      bit exp_borrow;
   } vec_t;

   vec_t vecs[14];
   logic [31:0] exp_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Driver: apply one control word to both instances, then advance past the edge.
   task automatic drive(input bit r, input bit ld, input bit e, input bit dir, input int lv);
      rst_n          = r;
      bus_a.load     = ld;
      bus_a.en       = e;
      bus_a.ctrl     = dir;
      bus_a.load_val = 4'(lv);
      bus_b.load     = ld;
      bus_b.en       = e;
      bus_b.ctrl     = dir;
      bus_b.load_val = 8'(lv);
      @(posedge clk);
      #1;
   endtask

   // Reference model: the counter rules stated as plain arithmetic on integers.
   task automatic ref_step(input int max_v, input int cur, input bit r, input bit ld,
                           input bit e, input bit dir, input int lv,
                           output int nxt, output bit car, output bit bor);
      car = 1'b0;
      bor = 1'b0;
      nxt = cur;
      if (!r) nxt = 0;
      else if (ld) nxt = (lv > max_v) ? max_v : lv;
      else if (e) begin
         if (dir) begin
            if (cur + 1 > max_v) begin
               car = 1'b1;
               nxt = SAT ? max_v : 0;
            end else nxt = cur + 1;
         end else begin
            if (cur - 1 < 0) begin
               bor = 1'b1;
               nxt = SAT ? 0 : max_v;
            end else nxt = cur - 1;
         end
      end
   endtask

   int  m_a, m_b;
   bit  mc_a, mb_a, mc_b, mb_b;

   initial begin
      rst_n = 1'b0;
      bus_a.load = 1'b0; bus_a.en = 1'b0; bus_a.ctrl = 1'b1; bus_a.load_val = '0;
      bus_b.load = 1'b0; bus_b.en = 1'b0; bus_b.ctrl = 1'b1; bus_b.load_val = '0;

      // rst, load, en, ctrl, load_val, exp_cnt, exp_carry, exp_borrow (dut_b, MAX 9)
      vecs[0]  = '{1, 1, 1, 1, 200, 9, 0, 0};
      vecs[1]  = '{1, 1, 1, 0, 5,   5, 0, 0};
      vecs[2]  = '{1, 0, 1, 0, 0,   4, 0, 0};
      vecs[3]  = '{1, 0, 0, 1, 0,   4, 0, 0};
      vecs[4]  = '{1, 0, 1, 1, 0,   5, 0, 0};
      vecs[5]  = '{1, 1, 0, 0, 7,   7, 0, 0};
      vecs[6]  = '{1, 0, 1, 1, 0,   8, 0, 0};
      vecs[7]  = '{1, 0, 1, 1, 0,   9, 0, 0};
      vecs[8]  = '{1, 0, 1, 1, 0,   SAT ? 9 : 0, 1, 0};
      vecs[9]  = '{1, 0, 0, 1, 0,   SAT ? 9 : 0, 0, 0};
      vecs[10] = '{1, 1, 0, 1, 0,   0, 0, 0};
      vecs[11] = '{1, 0, 1, 0, 0,   SAT ? 0 : 9, 0, 1};
      vecs[12] = '{1, 0, 1, 0, 0,   SAT ? 0 : 8, 0, SAT};
      vecs[13] = '{0, 1, 1, 1, 3,   0, 0, 0};

      // Reset state
      drive(0, 0, 0, 1, 0);
      check("rst_cnt_a", 32'(bus_a.cnt), 0);
      check("rst_carry_a", 32'(bus_a.carry), 0);
      check("rst_borrow_a", 32'(bus_a.borrow), 0);
      check("rst_at_min_a", 32'(bus_a.at_min), 1);
      check("rst_at_max_a", 32'(bus_a.at_max), 0);
      check("rst_cnt_b", 32'(bus_b.cnt), 0);

      // Full up sweep on the 4-bit instance through the terminal count
      for (int i = 1; i <= 16; i++) exp_q.push_back((i == 16) ? (SAT ? 15 : 0) : i);
      for (int i = 1; i <= 16; i++) begin
         drive(1, 0, 1, 1, 0);
         check("sweep_cnt", 32'(bus_a.cnt), exp_q.pop_front());
         check("sweep_carry", 32'(bus_a.carry), (i == 16) ? 1 : 0);
         check("sweep_borrow", 32'(bus_a.borrow), 0);
      end
      check("sweep_at_max", 32'(bus_a.at_max), SAT ? 1 : 0);
      if (SAT) begin
         for (int i = 0; i < 2; i++) begin
            drive(1, 0, 1, 1, 0);
            check("sat_hold_cnt", 32'(bus_a.cnt), 15);
            check("sat_hold_carry", 32'(bus_a.carry), 1);
         end
         drive(1, 0, 0, 1, 0);
         check("sat_idle_carry", 32'(bus_a.carry), 0);
         check("sat_idle_cnt", 32'(bus_a.cnt), 15);
      end else begin
         drive(1, 0, 1, 1, 0);
         check("post_wrap_cnt", 32'(bus_a.cnt), 1);
         check("post_wrap_carry", 32'(bus_a.carry), 0);
      end

      // Vector table on the 8-bit / MAX 9 instance
      drive(0, 0, 0, 1, 0);
      for (int i = 0; i < 14; i++) begin
         drive(vecs[i].rst_n, vecs[i].load, vecs[i].en, vecs[i].ctrl, vecs[i].load_val);
         check($sformatf("vec%0d_cnt", i), 32'(bus_b.cnt), vecs[i].exp_cnt);
         check($sformatf("vec%0d_carry", i), 32'(bus_b.carry), 32'(vecs[i].exp_carry));
         check($sformatf("vec%0d_borrow", i), 32'(bus_b.borrow), 32'(vecs[i].exp_borrow));
         check($sformatf("vec%0d_at_max", i), 32'(bus_b.at_max), (vecs[i].exp_cnt == MAX_B) ? 1 : 0);
         check($sformatf("vec%0d_at_min", i), 32'(bus_b.at_min), (vecs[i].exp_cnt == 0) ? 1 : 0);
      end

      // Reset wins over load while counting at 7
      drive(1, 1, 0, 1, 6);
      drive(1, 0, 1, 1, 0);
      check("pre_rst_cnt", 32'(bus_b.cnt), 7);
      drive(0, 1, 1, 1, 4);
      check("rst_ld_cnt", 32'(bus_b.cnt), 0);
      check("rst_ld_carry", 32'(bus_b.carry), 0);
      check("rst_ld_borrow", 32'(bus_b.borrow), 0);
      check("rst_ld_at_min", 32'(bus_b.at_min), 1);

      // Reset at a wrap edge suppresses the pulse
      drive(1, 1, 0, 1, 9);
      drive(0, 0, 1, 1, 0);
      check("rst_wrap_cnt", 32'(bus_b.cnt), 0);
      check("rst_wrap_carry", 32'(bus_b.carry), 0);

      // Randomized run on both instances against the model
      drive(0, 0, 0, 1, 0);
      m_a = 0; m_b = 0;
      for (int cyc = 0; cyc < 1000; cyc++) begin
         bit r, ld, e, dir;
         int lv;
         r   = ($urandom_range(0, 39) != 0);
         ld  = ($urandom_range(0, 7) == 0);
         e   = ($urandom_range(0, 3) != 0);
         dir = 1'($urandom_range(0, 1));
         lv  = $urandom_range(0, 255);
         drive(r, ld, e, dir, lv);
         ref_step(MAX_A, m_a, r, ld, e, dir, lv & 15, m_a, mc_a, mb_a);
         ref_step(MAX_B, m_b, r, ld, e, dir, lv, m_b, mc_b, mb_b);
         check("rnd_cnt_a", 32'(bus_a.cnt), m_a);
         check("rnd_carry_a", 32'(bus_a.carry), 32'(mc_a));
         check("rnd_borrow_a", 32'(bus_a.borrow), 32'(mb_a));
         check("rnd_at_max_a", 32'(bus_a.at_max), (m_a == MAX_A) ? 1 : 0);
         check("rnd_at_min_a", 32'(bus_a.at_min), (m_a == 0) ? 1 : 0);
         check("rnd_cnt_b", 32'(bus_b.cnt), m_b);
         check("rnd_carry_b", 32'(bus_b.carry), 32'(mc_b));
         check("rnd_borrow_b", 32'(bus_b.borrow), 32'(mb_b));
         check("rnd_at_max_b", 32'(bus_b.at_max), (m_b == MAX_B) ? 1 : 0);
         check("rnd_at_min_b", 32'(bus_b.at_min), (m_b == 0) ? 1 : 0);
      end

      // Final report
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
